mest_seq_ctrl: RTL and testbench

MEST_SEQ_CTRL -- requirements
Module: mest_seq_ctrl

---
 rtl/mest_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mest_seq_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mest_seq_ctrl.sv
// mest_seq_ctrl -- program sequencer for a small datapath.
//
// Fetches instruction words from a program ROM with a fixed read latency,
// decodes control opcodes (HALT, JMP and, optionally, JZ) locally and hands
// every other instruction to the datapath, waiting for its completion.
//
// Optional feature: define MEST_SEQ_BRANCH_EN to decode opcode 4'hD as JZ
// (conditional jump on the zero flag captured from the last datapath op).
// With the macro undefined, 4'hD is an ordinary datapath instruction and no
// zero-flag register is built.
//
// Ports
//   clk             single clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_start         start pulse, honoured only in IDLE
//   o_req           program-memory read request (one cycle per fetch)
//   o_prog_counter  program-memory read address
//   i_instruction   program-memory read data (opcode in MSBs, [7:0] target)
//   o_exec_valid    instruction presented to datapath
//   o_exec_instr    registered instruction to datapath
//   i_exec_done     datapath completed the presented instruction
//   i_zero_flag     datapath zero flag, valid with i_exec_done
//   o_busy          high in every state except IDLE
//   o_all_done      one-cycle program-complete pulse
//
// state  | meaning
// IDLE   | waiting for i_start
// FETCH  | o_req asserted for the current PC
// WAIT   | ROM read latency countdown
// DECODE | i_instruction sampled and decoded
// EXEC   | instruction held on the datapath until i_exec_done
// DONE   | o_all_done pulse, then back to IDLE
module mest_seq_ctrl #(
   parameter int OP_CODE_SIZE     = 4,
   parameter int INSTRUCTION_SIZE = OP_CODE_SIZE + 8 + 8 + 8,
   parameter int ROM_DEPTH        = 256,
   parameter int ROM_LATENCY      = 1,
   localparam int PCW             = $clog2(ROM_DEPTH)
) (
   input  logic                        clk,
   input  logic                        i_reset_n,
   input  logic                        i_start,
   output logic                        o_req,
   output logic [PCW-1:0]              o_prog_counter,
   input  logic [INSTRUCTION_SIZE-1:0] i_instruction,
   output logic                        o_exec_valid,
   output logic [INSTRUCTION_SIZE-1:0] o_exec_instr,
   input  logic                        i_exec_done,
   input  logic                        i_zero_flag,
   output logic                        o_busy,
   output logic                        o_all_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_DONE
   } state_t;

   localparam logic [OP_CODE_SIZE-1:0] OP_HALT = OP_CODE_SIZE'(4'hF);
   localparam logic [OP_CODE_SIZE-1:0] OP_JMP  = OP_CODE_SIZE'(4'hE);
   localparam logic [2:0]              WAIT_LOAD = 3'(ROM_LATENCY - 1);

   state_t                      state_q, state_d;
   logic [PCW-1:0]              pc_q, pc_d;
   logic [2:0]                  wcnt_q, wcnt_d;
   logic [INSTRUCTION_SIZE-1:0] instr_q, instr_d;

   logic [OP_CODE_SIZE-1:0] opcode;
   logic [PCW-1:0]          target;
   logic [PCW-1:0]          pc_inc;
   logic                    last_addr;

   assign opcode    = i_instruction[INSTRUCTION_SIZE-1 -: OP_CODE_SIZE];
   assign target    = PCW'(i_instruction[7:0]);
   assign pc_inc    = pc_q + PCW'(1);
   assign last_addr = (pc_q == PCW'(ROM_DEPTH - 1));

`ifdef MEST_SEQ_BRANCH_EN
   localparam logic [OP_CODE_SIZE-1:0] OP_JZ = OP_CODE_SIZE'(4'hD);
   logic z_q, z_d;
`else
   logic unused_zero_flag;
   assign unused_zero_flag = i_zero_flag;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      wcnt_d  = wcnt_q;
      instr_d = instr_q;
`ifdef MEST_SEQ_BRANCH_EN
      z_d     = z_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               pc_d    = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            wcnt_d  = WAIT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wcnt_q == 3'd0) state_d = S_DECODE;
            else                wcnt_d  = wcnt_q - 3'd1;
         end
         S_DECODE: begin
            if (opcode == OP_HALT) begin
               state_d = S_DONE;
            end else if (opcode == OP_JMP) begin
               pc_d    = target;
               state_d = S_FETCH;
`ifdef MEST_SEQ_BRANCH_EN
            end else if (opcode == OP_JZ) begin
               // Taken jumps go anywhere; a fall-through obeys the no-wrap rule.
               if (z_q) begin
                  pc_d    = target;
                  state_d = S_FETCH;
               end else if (last_addr) begin
                  state_d = S_DONE;
               end else begin
                  pc_d    = pc_inc;
                  state_d = S_FETCH;
               end
`endif
            end else begin
               instr_d = i_instruction;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (i_exec_done) begin
`ifdef MEST_SEQ_BRANCH_EN
               z_d = i_zero_flag;
`endif
               if (last_addr) begin
                  state_d = S_DONE;
               end else begin
                  pc_d    = pc_inc;
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         wcnt_q  <= 3'd0;
         instr_q <= '0;
`ifdef MEST_SEQ_BRANCH_EN
         z_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wcnt_q  <= wcnt_d;
         instr_q <= instr_d;
`ifdef MEST_SEQ_BRANCH_EN
         z_q     <= z_d;
`endif
      end
   end

   // Outputs decode straight from the state register so reset clears them
   // in the same cycle it is asserted.
   assign o_req          = (state_q == S_FETCH);
   assign o_exec_valid   = (state_q == S_EXEC);
   assign o_busy         = (state_q != S_IDLE);
   assign o_all_done     = (state_q == S_DONE);
   assign o_prog_counter = pc_q;
   assign o_exec_instr   = instr_q;

endmodule

// File: tb/tb_mest_seq_ctrl.sv
module tb_mest_seq_ctrl;

   localparam int IW    = 28;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   logic clk = 1'b0;
   logic i_reset_n;
   always #5 clk = ~clk;

   // instance A: ROM_DEPTH 256, latency 1
   logic          start_a, req_a, valid_a, done_a, zf_a, busy_a, alld_a;
   logic [7:0]    pc_a;
   logic [IW-1:0] rdata_a, einstr_a;
   // instance B: ROM_DEPTH 4, latency 3
   logic          start_b, req_b, valid_b, done_b, zf_b, busy_b, alld_b;
   logic [1:0]    pc_b;
   logic [IW-1:0] rdata_b, einstr_b;

   mest_seq_ctrl #(.ROM_DEPTH(256), .ROM_LATENCY(LAT_A)) dut_a (
      .clk(clk), .i_reset_n(i_reset_n), .i_start(start_a), .o_req(req_a),
      .o_prog_counter(pc_a), .i_instruction(rdata_a), .o_exec_valid(valid_a),
      .o_exec_instr(einstr_a), .i_exec_done(done_a), .i_zero_flag(zf_a),
      .o_busy(busy_a), .o_all_done(alld_a));

   mest_seq_ctrl #(.ROM_DEPTH(4), .ROM_LATENCY(LAT_B)) dut_b (
      .clk(clk), .i_reset_n(i_reset_n), .i_start(start_b), .o_req(req_b),
      .o_prog_counter(pc_b), .i_instruction(rdata_b), .o_exec_valid(valid_b),
      .o_exec_instr(einstr_b), .i_exec_done(done_b), .i_zero_flag(zf_b),
      .o_busy(busy_b), .o_all_done(alld_b));

   int n_cmp = 0;
   int n_err = 0;

   int done_dly = 0;     // EXEC cycles before i_exec_done is raised
   logic done_out = 1'b1; // i_exec_done level outside EXEC (must be ignored)
   logic zf_val = 1'b0;  // zero flag presented together with done

   logic [IW-1:0] rom_a [256];
   logic [IW-1:0] rom_b [4];

   function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [7:0] tgt);
      return {op, 8'h5A, 8'hC3, tgt};
   endfunction

   // ROM models: data valid LAT cycles after the o_req cycle, then held.
   int rcnt_a = 0, raddr_a = 0, rcnt_b = 0, raddr_b = 0;
   always @(posedge clk) begin
      if (req_a) begin
         if (LAT_A == 1) rdata_a <= rom_a[pc_a];
         else begin rdata_a <= 28'h0BADBAD; raddr_a <= int'(pc_a); rcnt_a <= LAT_A - 1; end
      end else if (rcnt_a > 0) begin
         rcnt_a <= rcnt_a - 1;
         if (rcnt_a == 1) rdata_a <= rom_a[raddr_a];
      end
      if (req_b) begin
         rdata_b <= 28'h0BADBAD; raddr_b <= int'(pc_b); rcnt_b <= LAT_B - 1;
      end else if (rcnt_b > 0) begin
         rcnt_b <= rcnt_b - 1;
         if (rcnt_b == 1) rdata_b <= rom_b[raddr_b];
      end
   end

   // Monitors and datapath responders, sampled on the falling edge.
   int fetch_a[$], exec_a[$], len_a[$], fetch_b[$], exec_b[$];
   logic [IW-1:0] ilog_a[$];
   int ndone_a = 0, ndone_b = 0, stab_err = 0, elen_a = 0, ecnt_a = 0, ecnt_b = 0;
   logic vprev_a = 1'b0, vprev_b = 1'b0;
   logic [IW-1:0] iprev_a = '0;

   always @(negedge clk) begin
      if (req_a) fetch_a.push_back(int'(pc_a));
      if (valid_a && !vprev_a) begin
         exec_a.push_back(int'(pc_a)); ilog_a.push_back(einstr_a); elen_a = 0;
      end
      if (valid_a) begin
         elen_a++;
         if (vprev_a && einstr_a !== iprev_a) stab_err++;
      end
      if (!valid_a && vprev_a) len_a.push_back(elen_a);
      if (alld_a) ndone_a++;
      vprev_a = valid_a; iprev_a = einstr_a;
      if (valid_a) begin done_a = (ecnt_a == done_dly); ecnt_a++; end
      else begin done_a = done_out; ecnt_a = 0; end
      zf_a = (valid_a && done_a) ? zf_val : !zf_val;

      if (req_b) fetch_b.push_back(int'(pc_b));
      if (valid_b && !vprev_b) exec_b.push_back(int'(pc_b));
      if (alld_b) ndone_b++;
      vprev_b = valid_b;
      if (valid_b) begin done_b = (ecnt_b == done_dly); ecnt_b++; end
      else begin done_b = done_out; ecnt_b = 0; end
      zf_b = !zf_val;
   end

   function automatic bit q_eq(input int a[$], input int b[$]);
      if (a.size() != b.size()) return 1'b0;
      foreach (a[i]) if (a[i] != b[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic clear_logs();
      fetch_a.delete(); exec_a.delete(); len_a.delete(); ilog_a.delete();
      fetch_b.delete(); exec_b.delete();
      ndone_a = 0; ndone_b = 0; stab_err = 0;
   endtask

   task automatic start_prog_a();
      @(posedge clk); #1 clear_logs();
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
   endtask

   task automatic wait_done_a(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #2;
         if (ndone_a != 0) begin ok = 1'b1; break; end
      end
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      i_reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
      #12;
      start_a = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if ({req_a, valid_a, busy_a, alld_a} !== 4'b0)
         begin n_err++; $display("FAIL reset_ctrl: got %b want 0000", {req_a, valid_a, busy_a, alld_a}); end
      n_cmp++; if (pc_a !== 8'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", pc_a); end
      n_cmp++; if (einstr_a !== '0) begin n_err++; $display("FAIL reset_instr: got %h want 0", einstr_a); end
      n_cmp++; if ({req_b, valid_b, busy_b, alld_b} !== 4'b0)
         begin n_err++; $display("FAIL reset_ctrl_b: got %b want 0000", {req_b, valid_b, busy_b, alld_b}); end
      @(negedge clk); start_a = 1'b0; #2 i_reset_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_release_idle: busy got %b want 0", busy_a); end
   endtask

   task automatic test_latency();
      int cnt;
      bit ok;
      rom_a[0] = mk(4'h1, 8'h00); rom_a[1] = mk(4'hF, 8'h00);
      done_dly = 0;
      @(posedge clk); #1 clear_logs();
      @(negedge clk); start_a = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); cnt++;
         @(negedge clk); start_a = 1'b0;
         if (valid_a) break;
      end
      n_cmp++; if (cnt !== 3 + LAT_A) begin n_err++; $display("FAIL latency_a: got %0d cycles want %0d", cnt, 3 + LAT_A); end
      wait_done_a(100, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL latency_a_done: o_all_done not seen, want 1 pulse"); end
      n_cmp++; if (fetch_a.size() < 1 || fetch_a[0] != 0)
         begin n_err++; $display("FAIL first_fetch_pc: got %p want first 0", fetch_a); end
      n_cmp++; if (!q_eq(len_a, '{1}))
         begin n_err++; $display("FAIL done_first_cycle: exec lengths %p want '{1}", len_a); end

      // instance B: ROM_DEPTH 4, no HALT, latency 3
      for (int k = 0; k < 4; k++) rom_b[k] = mk(4'h3, 8'(k));
      @(negedge clk); start_b = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); cnt++;
         @(negedge clk); start_b = 1'b0;
         if (valid_b) break;
      end
      n_cmp++; if (cnt !== 3 + LAT_B) begin n_err++; $display("FAIL latency_b: got %0d cycles want %0d", cnt, 3 + LAT_B); end
      for (int i = 0; i < 200 && ndone_b == 0; i++) begin @(posedge clk); #2; end
      repeat (10) @(posedge clk);
      #2;
      n_cmp++; if (!q_eq(fetch_b, '{0, 1, 2, 3}))
         begin n_err++; $display("FAIL depth_end_fetch: got %p want '{0,1,2,3}", fetch_b); end
      n_cmp++; if (!q_eq(exec_b, '{0, 1, 2, 3}))
         begin n_err++; $display("FAIL depth_end_exec: got %p want '{0,1,2,3}", exec_b); end
      n_cmp++; if (ndone_b !== 1) begin n_err++; $display("FAIL depth_end_done: got %0d pulses want 1", ndone_b); end
      n_cmp++; if (pc_b !== 2'd3 || busy_b !== 1'b0)
         begin n_err++; $display("FAIL depth_end_idle: pc %0d busy %b want pc 3 busy 0", pc_b, busy_b); end
   endtask

   task automatic test_program();
      bit ok;
      rom_a[0] = mk(4'h1, 8'h11); rom_a[1] = mk(4'h2, 8'h22); rom_a[2] = mk(4'hF, 8'h00);
      done_dly = 2; done_out = 1'b1;
      start_prog_a();
      wait_done_a(200, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL prog_timeout: o_all_done not seen, want 1 pulse"); end
      n_cmp++; if (!q_eq(fetch_a, '{0, 1, 2}))
         begin n_err++; $display("FAIL prog_fetch: got %p want '{0,1,2}", fetch_a); end
      n_cmp++; if (!q_eq(exec_a, '{0, 1}))
         begin n_err++; $display("FAIL prog_exec: got %p want '{0,1}", exec_a); end
      n_cmp++; if (!q_eq(len_a, '{3, 3}))
         begin n_err++; $display("FAIL prog_exec_len: got %p want '{3,3}", len_a); end
      n_cmp++; if (ilog_a.size() != 2 || ilog_a[0] !== mk(4'h1, 8'h11) || ilog_a[1] !== mk(4'h2, 8'h22))
         begin n_err++; $display("FAIL prog_instr: got %p want %h %h", ilog_a, mk(4'h1, 8'h11), mk(4'h2, 8'h22)); end
      n_cmp++; if (ndone_a !== 1 || stab_err !== 0)
         begin n_err++; $display("FAIL prog_done_stable: pulses %0d instability %0d want 1 and 0", ndone_a, stab_err); end
   endtask

   task automatic test_start_ignored();
      bit ok;
      rom_a[0] = mk(4'h1, 8'h00); rom_a[1] = mk(4'hF, 8'h00);
      done_dly = 8;
      start_prog_a();
      for (int i = 0; i < 30 && !valid_a; i++) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      wait_done_a(200, ok);
      n_cmp++; if (!q_eq(fetch_a, '{0, 1}) || !ok)
         begin n_err++; $display("FAIL start_ignored: fetch %p done %b want '{0,1} done 1", fetch_a, ok); end
   endtask

   task automatic test_jmp();
      bit ok;
      rom_a[0] = mk(4'hE, 8'h05); rom_a[5] = mk(4'hF, 8'h00);
      done_dly = 0;
      start_prog_a();
      wait_done_a(200, ok);
      n_cmp++; if (!q_eq(fetch_a, '{0, 5}))
         begin n_err++; $display("FAIL jmp_fetch: got %p want '{0,5}", fetch_a); end
      n_cmp++; if (exec_a.size() != 0 || ndone_a !== 1)
         begin n_err++; $display("FAIL jmp_exec_done: exec %p pulses %0d want none and 1", exec_a, ndone_a); end
   endtask

   task automatic test_jmp_loop();
      bit all0;
      rom_a[0] = mk(4'hE, 8'h00);
      start_prog_a();
      repeat (60) @(posedge clk);
      #2;
      all0 = 1'b1;
      foreach (fetch_a[i]) if (fetch_a[i] != 0) all0 = 1'b0;
      n_cmp++; if (!all0 || fetch_a.size() < 10 || ndone_a != 0 || busy_a !== 1'b1)
         begin n_err++; $display("FAIL jmp_self_loop: fetches %0d all0 %b done %0d busy %b want >=10 1 0 1",
                                 fetch_a.size(), all0, ndone_a, busy_a); end
      @(negedge clk); i_reset_n = 1'b0;
      @(negedge clk); i_reset_n = 1'b1;
   endtask

   task automatic test_branch();
      bit ok;
`ifdef MEST_SEQ_BRANCH_EN
      rom_a[0] = mk(4'h1, 8'h00); rom_a[1] = mk(4'hD, 8'h0A);
      rom_a[2] = mk(4'hF, 8'h00); rom_a[10] = mk(4'hF, 8'h00);
      done_dly = 1; zf_val = 1'b1;
      start_prog_a();
      wait_done_a(200, ok);
      n_cmp++; if (!q_eq(fetch_a, '{0, 1, 10}) || !q_eq(exec_a, '{0}))
         begin n_err++; $display("FAIL jz_taken: fetch %p exec %p want '{0,1,10} '{0}", fetch_a, exec_a); end
      zf_val = 1'b0;
      start_prog_a();
      wait_done_a(200, ok);
      n_cmp++; if (!q_eq(fetch_a, '{0, 1, 2}) || !q_eq(exec_a, '{0}))
         begin n_err++; $display("FAIL jz_not_taken: fetch %p exec %p want '{0,1,2} '{0}", fetch_a, exec_a); end
`else
      rom_a[0] = mk(4'hD, 8'h0A); rom_a[1] = mk(4'hF, 8'h00);
      done_dly = 1; zf_val = 1'b1;
      start_prog_a();
      wait_done_a(200, ok);
      n_cmp++; if (!q_eq(fetch_a, '{0, 1}) || !q_eq(exec_a, '{0}))
         begin n_err++; $display("FAIL opD_datapath: fetch %p exec %p want '{0,1} '{0}", fetch_a, exec_a); end
      n_cmp++; if (ilog_a.size() != 1 || ilog_a[0] !== mk(4'hD, 8'h0A))
         begin n_err++; $display("FAIL opD_instr: got %p want %h", ilog_a, mk(4'hD, 8'h0A)); end
`endif
      zf_val = 1'b0;
   endtask

   task automatic test_reset_mid_exec();
      bit ok;
      for (int k = 0; k < 4; k++) rom_a[k] = mk(4'h1, 8'(k));
      rom_a[4] = mk(4'hF, 8'h00);
      done_dly = 20;
      start_prog_a();
      for (int i = 0; i < 400 && !(valid_a && pc_a == 8'd3); i++) @(negedge clk);
      n_cmp++; if (!(valid_a && pc_a == 8'd3))
         begin n_err++; $display("FAIL rst_exec_reach: valid %b pc %0d want 1 and 3", valid_a, pc_a); end
      i_reset_n = 1'b0;
      #1;
      n_cmp++; if (valid_a !== 1'b0 || busy_a !== 1'b0)
         begin n_err++; $display("FAIL rst_exec_drop: valid %b busy %b want 0 0", valid_a, busy_a); end
      n_cmp++; if (pc_a !== 8'd0 || einstr_a !== '0)
         begin n_err++; $display("FAIL rst_exec_clear: pc %0d instr %h want 0 0", pc_a, einstr_a); end
      repeat (3) @(negedge clk);
      i_reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      n_cmp++; if (ndone_a !== 0) begin n_err++; $display("FAIL rst_exec_no_done: got %0d pulses want 0", ndone_a); end
      done_dly = 0;
      start_prog_a();
      wait_done_a(300, ok);
      n_cmp++; if (!q_eq(fetch_a, '{0, 1, 2, 3, 4}) || ndone_a !== 1)
         begin n_err++; $display("FAIL rst_restart: fetch %p pulses %0d want '{0,1,2,3,4} 1", fetch_a, ndone_a); end
   endtask

   initial begin
      done_a = 1'b0; zf_a = 1'b0; done_b = 1'b0; zf_b = 1'b0;
      rdata_a = '0; rdata_b = '0;
      for (int k = 0; k < 256; k++) rom_a[k] = mk(4'hF, 8'h00);
      test_reset();
      test_latency();
      test_program();
      test_start_ignored();
      test_jmp();
      test_jmp_loop();
      test_branch();
      test_reset_mid_exec();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
